// File: rtl/multi_port_sdram.sv
`default_nettype none
// ============================================================================
// Module  : multi_port_sdram
// Brief   : Round-robin arbitrated multi-port byte-addressed word memory
//           with fixed read/write latencies and four-phase fin handshake.
// Revision: 1.0
// ============================================================================
module multi_port_sdram #(
  parameter int MEM_SIZE   = 65536,
  parameter int NPORTS     = 2,
  parameter int RD_LAT     = 3,
  parameter int WR_LAT     = 2,
  parameter int BIG_ENDIAN = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NPORTS-1:0]     req,
  input  logic [NPORTS-1:0]     we,
  input  logic [32*NPORTS-1:0]  addr,
  input  logic [32*NPORTS-1:0]  wdata,
  input  logic [4*NPORTS-1:0]   be,
  output logic [NPORTS-1:0]     fin,
  output logic [32*NPORTS-1:0]  rdata,
  output logic                  busy
);

  localparam int c_AW     = $clog2(MEM_SIZE);
  localparam int c_PW     = (NPORTS > 1) ? $clog2(NPORTS) : 1;
  localparam int c_MAXLAT = (RD_LAT > WR_LAT) ? RD_LAT : WR_LAT;
  localparam int c_CW     = (c_MAXLAT > 1) ? $clog2(c_MAXLAT) : 1;

  localparam logic [1:0] c_IDLE   = 2'd0;
  localparam logic [1:0] c_ACCESS = 2'd1;
  localparam logic [1:0] c_DONE   = 2'd2;

  logic [1:0]        r_state, w_next_state;
  logic [c_PW-1:0]   r_rr, r_port, w_gnt;
  logic              w_any, w_grant, w_do_access;
  logic              r_we;
  logic [c_AW-3:0]   r_word;
  logic [31:0]       r_wdata;
  logic [3:0]        r_be;
  logic [c_CW-1:0]   r_cnt;
  logic [NPORTS-1:0] w_pend;
  logic [31:0]       w_gnt_addr;
  logic [31:0]       w_rword;
  logic              w_unused_addr;
  logic [7:0]        r_mem [MEM_SIZE];

  // Byte k of the data word lives at this offset within the aligned word.
  function automatic logic [1:0] byte_lane(input int k);
    return (BIG_ENDIAN != 0) ? 2'(3 - k) : 2'(k);
  endfunction

  function automatic logic [c_PW-1:0] wrap_idx(input int v);
    return c_PW'(v % NPORTS);
  endfunction

  // A port that already holds fin is not eligible until it drops req.
  assign w_pend        = req & ~fin;
  assign w_gnt_addr    = addr[32*w_gnt +: 32];
  assign w_unused_addr = ^w_gnt_addr;

  // Scan downward so the last hit is the closest one at or after r_rr.
  always_comb begin
    w_any = 1'b0;
    w_gnt = '0;
    for (int i = NPORTS - 1; i >= 0; i--) begin
      if (w_pend[wrap_idx(int'(r_rr) + i)]) begin
        w_any = 1'b1;
        w_gnt = wrap_idx(int'(r_rr) + i);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= c_IDLE;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_IDLE:   if (w_any) w_next_state = c_ACCESS;
      c_ACCESS: if (r_cnt == '0) w_next_state = c_DONE;
      c_DONE:   w_next_state = c_IDLE;
      default:  w_next_state = c_IDLE;
    endcase
  end

  always_comb begin
    busy        = (r_state != c_IDLE);
    w_grant     = (r_state == c_IDLE) && w_any;
    w_do_access = (r_state == c_ACCESS) && (r_cnt == '0);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rr    <= '0;
      r_port  <= '0;
      r_we    <= 1'b0;
      r_word  <= '0;
      r_wdata <= '0;
      r_be    <= '0;
      r_cnt   <= '0;
      fin     <= '0;
      rdata   <= '0;
    end else begin
      if (w_grant) begin
        r_port  <= w_gnt;
        r_we    <= we[w_gnt];
        r_word  <= w_gnt_addr[c_AW-1:2];
        r_wdata <= wdata[32*w_gnt +: 32];
        r_be    <= be[4*w_gnt +: 4];
        r_cnt   <= we[w_gnt] ? c_CW'(WR_LAT - 1) : c_CW'(RD_LAT - 1);
        r_rr    <= (int'(w_gnt) == NPORTS - 1) ? '0 : w_gnt + 1'b1;
      end else if ((r_state == c_ACCESS) && (r_cnt != '0)) begin
        r_cnt <= r_cnt - 1'b1;
      end
      if (w_do_access && !r_we) rdata[32*r_port +: 32] <= w_rword;
      // Setting fin in DONE wins over clearing, so an early req drop still pulses fin.
      for (int p = 0; p < NPORTS; p++) begin
        if ((r_state == c_DONE) && (int'(r_port) == p)) fin[p] <= 1'b1;
        else if (!req[p])                               fin[p] <= 1'b0;
      end
    end
  end

  // Storage has no reset; an aborted write never reaches this enable.
  always_ff @(posedge clk) begin
    if (w_do_access && r_we) begin
      for (int k = 0; k < 4; k++) begin
        if (r_be[k]) r_mem[{r_word, byte_lane(k)}] <= r_wdata[8*k +: 8];
      end
    end
  end

  always_comb begin
    w_rword = '0;
    for (int k = 0; k < 4; k++) w_rword[8*k +: 8] = r_mem[{r_word, byte_lane(k)}];
  end

endmodule
`default_nettype wire
